// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC register slave: state encoding,
// default counter width and the saturating increment helper.
package fsmc_pkg;

    // Bit positions of the one-hot state vector
    localparam int ST_IDLE  = 0;
    localparam int ST_WRITE = 1;
    localparam int ST_READ1 = 2;
    localparam int ST_READ2 = 3;

    localparam int CNTW_DEFAULT = 8;

    typedef enum logic [3:0] {
        IDLE  = 4'(1 << ST_IDLE),
        WRITE = 4'(1 << ST_WRITE),
        READ1 = 4'(1 << ST_READ1),
        READ2 = 4'(1 << ST_READ2)
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] maxv;
        if (w >= 32) begin
            maxv = '1;
        end else begin
            maxv = (32'd1 << w) - 32'd1;
        end
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/fsmc_sync.sv
// Multi-stage synchroniser for asynchronous inputs with a selectable
// reset value, so idle-high strobes read as inactive straight after reset.
module fsmc_sync #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    // Shift the asynchronous input through STAGES flops
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RST_VAL;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fsmc_reg_slave.sv
// FSMC register-file slave: synchronises the bus strobes, serialises
// read/write transactions and owns a bank of NREG registers with
// read-only, auto-increment and sequence-check masks plus error counters.
module fsmc_reg_slave
    import fsmc_pkg::*;
#(
    parameter int              ADRW        = 2,
    parameter int              DATW        = 3,
    parameter int              NREG        = 4,
    parameter int              SYNC_STAGES = 2,
    parameter logic [NREG-1:0] RO_MASK     = '0,
    parameter logic [NREG-1:0] INC_MASK    = '0,
    parameter logic [NREG-1:0] CHK_MASK    = '0,
    parameter int              CNTW        = CNTW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 aNE,
    input  logic                 aNOE,
    input  logic                 aNWE,
    input  logic [ADRW-1:0]      aAn,
    input  logic [DATW-1:0]      aDn_in,
    output logic                 io_output,
    output logic [DATW-1:0]      io_data,
    output logic [ADRW-1:0]      rw_adr,
    output logic                 do_read,
    output logic                 do_write,
    output logic [DATW-1:0]      w_data,
    output logic [NREG*DATW-1:0] regs,
    output logic [CNTW-1:0]      err_cnt,
    output logic [CNTW-1:0]      viol_cnt
);

    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic sNE, sNOE, sNWE;

    fsmc_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ne (
        .clk(clk), .nrst(nrst), .d(aNE), .q(sNE)
    );
    fsmc_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_noe (
        .clk(clk), .nrst(nrst), .d(aNOE), .q(sNOE)
    );
    fsmc_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nwe (
        .clk(clk), .nrst(nrst), .d(aNWE), .q(sNWE)
    );

    state_t          state, state_nx;
    logic            armed;
    logic [SW-1:0]   settle;
    logic            settled;
    logic            start_wr, start_rd, collide;
    logic [DATW-1:0] reg_q [NREG];
    logic [DATW-1:0] rd_val;
    logic            err_evt, ro_evt;

    // The synchroniser reset value is not a real sample of the bus, so
    // arming waits until the chain holds genuine input.
    assign settled = (settle == SW'(SYNC_STAGES));

    // State register plus the post-reset arming logic
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            armed  <= 1'b0;
            settle <= '0;
        end else begin
            state <= state_nx;
            if (!settled) begin
                settle <= settle + SW'(1);
            end
            if (settled && sNE) begin
                armed <= 1'b1;
            end
        end
    end

    // Next-state decode, transaction starts and bus drive enable
    always_comb begin
        state_nx  = state;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        collide   = 1'b0;
        io_output = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !sNE && !sNWE) begin
                    start_wr = 1'b1;
                    collide  = !sNOE;
                    state_nx = WRITE;
                end else if (armed && !sNE && !sNOE) begin
                    start_rd = 1'b1;
                    state_nx = READ1;
                end
            end
            WRITE: begin
                if (sNE || sNWE) begin
                    state_nx = IDLE;
                end
            end
            READ1: begin
                state_nx = (!sNE && !sNOE) ? READ2 : IDLE;
            end
            READ2: begin
                if (sNE || sNOE) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        io_output = (state == READ2) && (state_nx == READ2);
    end

    // Transaction strobes and the latched address/data/read value
    always_ff @(posedge clk) begin
        if (!nrst) begin
            do_write <= 1'b0;
            do_read  <= 1'b0;
            rw_adr   <= '0;
            w_data   <= '0;
            io_data  <= '0;
        end else begin
            do_write <= start_wr;
            do_read  <= start_rd;
            if (start_wr || start_rd) begin
                rw_adr <= aAn;
            end
            if (start_wr) begin
                w_data <= aDn_in;
            end
            if (state == READ1) begin
                io_data <= rd_val;
            end
        end
    end

    // Read mux and write-side event detection; unimplemented addresses read 0
    always_comb begin
        rd_val  = '0;
        err_evt = 1'b0;
        ro_evt  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (rw_adr == ADRW'(i)) begin
                rd_val = reg_q[i];
                if (do_write && RO_MASK[i]) begin
                    ro_evt = 1'b1;
                end
                if (do_write && CHK_MASK[i] && (w_data != DATW'(reg_q[i] + DATW'(1)))) begin
                    err_evt = 1'b1;
                end
            end
        end
    end

    // Register bank updates and saturating counters
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
            err_cnt  <= '0;
            viol_cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rw_adr == ADRW'(i)) begin
                    if (do_write && !RO_MASK[i]) begin
                        reg_q[i] <= w_data;
                    end else if ((state == READ1) && INC_MASK[i]) begin
                        reg_q[i] <= reg_q[i] + DATW'(1);
                    end
                end
            end
            if (err_evt) begin
                err_cnt <= CNTW'(sat_inc(32'(err_cnt), CNTW));
            end
            if (ro_evt || collide) begin
                viol_cnt <= CNTW'(sat_inc(32'(viol_cnt), CNTW));
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign regs[g*DATW +: DATW] = reg_q[g];
    end

endmodule

// File: tb/tb_fsmc_reg_slave.sv
// Bench for fsmc_reg_slave: two differently configured instances share one
// stimulus bus; a transaction-level model predicts every output each cycle
// and directed literal checks pin the model to hand-computed values.
module tb_fsmc_reg_slave;

    localparam int SYNC = 2;
    localparam logic [3:0] M_RO  [2] = '{4'b0010, 4'b0000};
    localparam logic [3:0] M_INC [2] = '{4'b0100, 4'b0000};
    localparam logic [3:0] M_CHK [2] = '{4'b0001, 4'b0001};
    localparam int         M_NREG[2] = '{4, 3};
    localparam int         M_MAX [2] = '{255, 3};

    logic       clk = 1'b0;
    logic       nrst;
    logic       aNE, aNOE, aNWE;
    logic [1:0] aAn;
    logic [2:0] aDn_in;

    logic        io_output0, io_output1;
    logic [2:0]  io_data0, io_data1, w_data0, w_data1;
    logic [1:0]  rw_adr0, rw_adr1;
    logic        do_read0, do_read1, do_write0, do_write1;
    logic [11:0] regs0;
    logic [8:0]  regs1;
    logic [7:0]  err_cnt0, viol_cnt0;
    logic [1:0]  err_cnt1, viol_cnt1;

    always #5 clk = ~clk;

    fsmc_reg_slave #(
        .ADRW(2), .DATW(3), .NREG(4), .SYNC_STAGES(SYNC),
        .RO_MASK(4'b0010), .INC_MASK(4'b0100), .CHK_MASK(4'b0001), .CNTW(8)
    ) dut0 (
        .clk(clk), .nrst(nrst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE),
        .aAn(aAn), .aDn_in(aDn_in), .io_output(io_output0), .io_data(io_data0),
        .rw_adr(rw_adr0), .do_read(do_read0), .do_write(do_write0),
        .w_data(w_data0), .regs(regs0), .err_cnt(err_cnt0), .viol_cnt(viol_cnt0)
    );

    fsmc_reg_slave #(
        .ADRW(2), .DATW(3), .NREG(3), .SYNC_STAGES(SYNC),
        .RO_MASK(3'b000), .INC_MASK(3'b000), .CHK_MASK(3'b001), .CNTW(2)
    ) dut1 (
        .clk(clk), .nrst(nrst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE),
        .aAn(aAn), .aDn_in(aDn_in), .io_output(io_output1), .io_data(io_data1),
        .rw_adr(rw_adr1), .do_read(do_read1), .do_write(do_write1),
        .w_data(w_data1), .regs(regs1), .err_cnt(err_cnt1), .viol_cnt(viol_cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is "none", "write" or "read" with an age in cycles since it
    // started; registers and counters live in plain arrays per instance.
    bit         m_valid = 0;
    logic [2:0] mregs [2][4];
    int         merr [2], mviol [2];
    logic [2:0] m_iod [2];
    logic       m_dw, m_dr;
    logic [1:0] m_adr;
    logic [2:0] m_wd;
    int         m_kind, m_age, m_since;
    bit         m_armed;
    logic       hne [SYNC], hnoe [SYNC], hnwe [SYNC];
    logic       s_ne, s_noe, s_nwe;

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            m_valid = 1;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) mregs[d][i] = 3'd0;
                merr[d] = 0; mviol[d] = 0; m_iod[d] = 3'd0;
            end
            m_dw = 0; m_dr = 0; m_adr = 2'd0; m_wd = 3'd0;
            m_kind = 0; m_age = 0; m_since = 0; m_armed = 0;
            for (int i = 0; i < SYNC; i++) begin hne[i] = 1; hnoe[i] = 1; hnwe[i] = 1; end
            s_ne = 1; s_noe = 1; s_nwe = 1;
        end else begin
            bit sw, sr;
            // effects of the cycle that is ending
            for (int d = 0; d < 2; d++) begin
                if (m_dw && int'(m_adr) < M_NREG[d]) begin
                    if (M_CHK[d][m_adr] && m_wd != 3'(mregs[d][m_adr] + 3'd1))
                        merr[d] = sat(merr[d], M_MAX[d]);
                    if (M_RO[d][m_adr]) mviol[d] = sat(mviol[d], M_MAX[d]);
                    else mregs[d][m_adr] = m_wd;
                end
                if (m_kind == 2 && m_age == 1) begin
                    m_iod[d] = (int'(m_adr) < M_NREG[d]) ? mregs[d][m_adr] : 3'd0;
                    if (int'(m_adr) < M_NREG[d] && M_INC[d][m_adr])
                        mregs[d][m_adr] = mregs[d][m_adr] + 3'd1;
                end
            end
            // transaction start / progress
            sw = (m_kind == 0) && m_armed && !s_ne && !s_nwe;
            sr = (m_kind == 0) && m_armed && !s_ne && !s_noe && s_nwe;
            if (sw && !s_noe) for (int d = 0; d < 2; d++) mviol[d] = sat(mviol[d], M_MAX[d]);
            if (sw || sr) m_adr = aAn;
            if (sw) m_wd = aDn_in;
            if (m_kind != 0) begin
                if (s_ne || (m_kind == 1 ? s_nwe : s_noe)) m_kind = 0;
                else if (m_age < 3) m_age++;
            end else if (sw) begin
                m_kind = 1; m_age = 1;
            end else if (sr) begin
                m_kind = 2; m_age = 1;
            end
            m_dw = sw; m_dr = sr;
            if (m_since >= SYNC && s_ne) m_armed = 1;
            if (m_since < SYNC) m_since++;
            // strobes become visible SYNC edges after being driven
            for (int i = SYNC - 1; i > 0; i--) begin
                hne[i] = hne[i-1]; hnoe[i] = hnoe[i-1]; hnwe[i] = hnwe[i-1];
            end
            hne[0] = aNE; hnoe[0] = aNOE; hnwe[0] = aNWE;
            s_ne = hne[SYNC-1]; s_noe = hnoe[SYNC-1]; s_nwe = hnwe[SYNC-1];
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] er;
                logic        eio;
                er = 0;
                for (int i = 0; i < M_NREG[d]; i++) er = er | (32'(mregs[d][i]) << (3 * i));
                eio = (m_kind == 2) && (m_age >= 2) && !s_ne && !s_noe;
                chk("do_write",  d, d == 0 ? 32'(do_write0)  : 32'(do_write1),  32'(m_dw));
                chk("do_read",   d, d == 0 ? 32'(do_read0)   : 32'(do_read1),   32'(m_dr));
                chk("io_output", d, d == 0 ? 32'(io_output0) : 32'(io_output1), 32'(eio));
                chk("rw_adr",    d, d == 0 ? 32'(rw_adr0)    : 32'(rw_adr1),    32'(m_adr));
                chk("w_data",    d, d == 0 ? 32'(w_data0)    : 32'(w_data1),    32'(m_wd));
                chk("io_data",   d, d == 0 ? 32'(io_data0)   : 32'(io_data1),   32'(m_iod[d]));
                chk("regs",      d, d == 0 ? 32'(regs0)      : 32'(regs1),      er);
                chk("err_cnt",   d, d == 0 ? 32'(err_cnt0)   : 32'(err_cnt1),   32'(merr[d]));
                chk("viol_cnt",  d, d == 0 ? 32'(viol_cnt0)  : 32'(viol_cnt1),  32'(mviol[d]));
            end
        end
    end

    // event counters on instance 0 for the directed literal checks
    int cnt_dw = 0, cnt_dr = 0, cnt_io = 0;
    always @(negedge clk) begin
        if (do_write0 === 1'b1) cnt_dw++;
        if (do_read0 === 1'b1) cnt_dr++;
        if (io_output0 === 1'b1) cnt_io++;
    end

    task automatic clr_cnt();
        cnt_dw = 0; cnt_dr = 0; cnt_io = 0;
    endtask

    task automatic bus_cycle(input logic [1:0] a, input logic [2:0] dv,
                             input logic noe, input logic nwe, input int hold);
        @(posedge clk); #2;
        aAn = a; aDn_in = dv; aNE = 1'b0; aNOE = noe; aNWE = nwe;
        repeat (hold) @(posedge clk);
        #2;
        aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
        repeat (5) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [2:0] dv);
        bus_cycle(a, dv, 1'b1, 1'b0, 4);
    endtask

    task automatic bus_read(input logic [1:0] a, input int hold);
        bus_cycle(a, 3'd0, 1'b0, 1'b1, hold);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        nrst = 1'b0; aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; aAn = 2'd0; aDn_in = 3'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_regs",      0, 32'(regs0),      32'h0);
        chk("rst_io_output", 0, 32'(io_output0), 32'h0);
        chk("rst_err_cnt",   1, 32'(err_cnt1),   32'h0);
        nrst = 1'b1;
        repeat (4) @(posedge clk);
        #2;

        // plain write to reg1 (read-only on instance 0)
        clr_cnt();
        bus_write(2'd1, 3'b101);
        chk("wr_pulses",  0, 32'(cnt_dw),      32'd1);
        chk("wr_no_bus",  0, 32'(cnt_io),      32'd0);
        chk("wr_reg1",    1, 32'(regs1[5:3]),  32'd5);
        chk("ro_reg1",    0, 32'(regs0[5:3]),  32'd0);
        chk("ro_viol",    0, 32'(viol_cnt0),   32'd1);

        // sequence checker on reg0
        bus_write(2'd0, 3'd1);
        bus_write(2'd0, 3'd2);
        bus_write(2'd0, 3'd3);
        bus_write(2'd0, 3'd4);
        chk("seq_ok",     0, 32'(err_cnt0),    32'd0);
        bus_write(2'd0, 3'd6);
        chk("seq_err",    0, 32'(err_cnt0),    32'd1);
        bus_write(2'd0, 3'd7);
        bus_write(2'd0, 3'd0);
        chk("seq_wrap",   0, 32'(err_cnt0),    32'd1);
        chk("seq_reg0",   0, 32'(regs0[2:0]),  32'd0);

        // saturation of the narrow counter
        for (int k = 0; k < 5; k++) bus_write(2'd0, 3'd0);
        chk("sat_err",    1, 32'(err_cnt1),    32'd3);
        chk("wide_err",   0, 32'(err_cnt0),    32'd6);

        // auto-increment on read of reg2
        bus_write(2'd2, 3'd7);
        clr_cnt();
        bus_read(2'd2, 5);
        chk("inc_rd1",    0, 32'(io_data0),    32'd7);
        chk("bus_cycles", 0, 32'(cnt_io),      32'd3);
        bus_read(2'd2, 5);
        chk("inc_rd2",    0, 32'(io_data0),    32'd0);
        chk("inc_reg2",   0, 32'(regs0[8:6]),  32'd1);
        chk("noinc_rd",   1, 32'(io_data1),    32'd7);

        // NOE and NWE together: write wins, violation counted, no read
        clr_cnt();
        bus_cycle(2'd3, 3'd6, 1'b0, 1'b0, 4);
        chk("col_reads",  0, 32'(cnt_dr),      32'd0);
        chk("col_writes", 0, 32'(cnt_dw),      32'd1);
        chk("col_viol",   0, 32'(viol_cnt0),   32'd2);
        chk("col_reg1",   0, 32'(regs0[5:3]),  32'd0);
        chk("col_reg3",   0, 32'(regs0[11:9]), 32'd6);
        chk("col_viol",   1, 32'(viol_cnt1),   32'd1);

        // read of an unimplemented register returns 0
        bus_read(2'd3, 4);
        chk("rd_reg3",    0, 32'(io_data0),    32'd6);
        chk("rd_unimpl",  1, 32'(io_data1),    32'd0);

        // read too short to reach the bus-driving state
        clr_cnt();
        bus_read(2'd0, 1);
        chk("short_rd",   0, 32'(cnt_dr),      32'd1);
        chk("short_bus",  0, 32'(cnt_io),      32'd0);

        // reset in the middle of a read with the strobes held low
        @(posedge clk); #2;
        aAn = 2'd2; aNE = 1'b0; aNOE = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("mid_bus_on", 0, 32'(io_output0),  32'd1);
        nrst = 1'b0;
        @(posedge clk); #2;
        nrst = 1'b1;
        chk("rst_bus_off", 0, 32'(io_output0), 32'd0);
        clr_cnt();
        repeat (8) @(posedge clk);
        #2;
        chk("held_no_rd", 0, 32'(cnt_dr),      32'd0);
        chk("held_no_bus", 0, 32'(cnt_io),     32'd0);
        aNE = 1'b1; aNOE = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        bus_read(2'd2, 5);
        chk("fresh_rd",   0, 32'(cnt_dr),      32'd1);
        chk("fresh_data", 0, 32'(io_data0),    32'd0);
        chk("fresh_inc",  0, 32'(regs0[8:6]),  32'd1);

        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
